// File: rtl/vip_uart_mon.sv
// vip_uart_mon: multi-channel UART receive monitor.
// Each rx line is synchronized, decoded as an oversampled LSB-first 8-bit frame, and queued
// in a per-channel FIFO. The FIFOs merge round-robin into one valid/ready byte stream tagged
// with the source channel.
// Optional feature: define VIP_UART_MON_PARITY_EN for 8E1/8O1 frames (sense from OddParity);
// without it frames are 8N1 and parity_err_o is tied low.
module vip_uart_mon #(
  parameter int unsigned NumCh     = 2,
  parameter int unsigned BaudDiv   = 33,
  parameter int unsigned FifoDepth = 8,
  parameter bit          OddParity = 1'b0,
  localparam int unsigned ChW      = (NumCh > 1) ? $clog2(NumCh) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [NumCh-1:0]      rx_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [7:0]            m_data_o,
  output logic [ChW-1:0]        m_ch_o,
  output logic [NumCh-1:0]      frame_err_o,
  output logic [NumCh-1:0]      parity_err_o,
  output logic [NumCh-1:0]      overflow_o,
  output logic [NumCh*16-1:0]   rx_cnt_o
);

  localparam int unsigned CntW  = $clog2(BaudDiv);
  localparam int unsigned AddrW = $clog2(FifoDepth);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam logic [CntW-1:0] HalfLoad = CntW'(BaudDiv / 2 - 1);
  localparam logic [CntW-1:0] BaudLoad = CntW'(BaudDiv - 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StData,
`ifdef VIP_UART_MON_PARITY_EN
    StParity,
`endif
    StStop, StBreak
  } state_e;

  logic [NumCh-1:0] push, pop, empty;
  logic [7:0]       push_data [NumCh];
  logic [7:0]       head      [NumCh];

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    logic [2:0]      sync_q;  // [0],[1] synchronizer; [2] previous synchronized value
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            ferr_q;
    logic            rx_s, tick;

    assign rx_s = sync_q[1];
    assign tick = (cnt_q == '0);

    // Two-flop synchronizer plus history flop for falling-edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= '1;
      else         sync_q <= {sync_q[1], sync_q[0], rx_i[c]};
    end

`ifdef VIP_UART_MON_PARITY_EN
    logic perr_q;
    // Parity check at the mid-point of the parity bit; clear wins over a same-cycle error
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        perr_q <= 1'b0;
      end else if (clear_i) begin
        perr_q <= 1'b0;
      end else if (state_q == StParity && tick && (((^shift_q) ^ rx_s) != OddParity)) begin
        perr_q <= 1'b1;
      end
    end
    assign parity_err_o[c] = perr_q;
`endif

    // Frame decoder: samples each bit at its centre using the baud counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        bit_q   <= '0;
        shift_q <= '0;
        ferr_q  <= 1'b0;
      end else begin
        if (clear_i) ferr_q <= 1'b0;
        case (state_q)
          StIdle: begin
            if (sync_q[2] && !rx_s) begin
              cnt_q   <= HalfLoad;
              state_q <= StStart;
            end
          end
          StStart: begin
            if (!tick) begin
              cnt_q <= cnt_q - 1'b1;
            end else if (rx_s) begin
              state_q <= StIdle;  // start bit did not hold: glitch
            end else begin
              cnt_q   <= BaudLoad;
              bit_q   <= '0;
              state_q <= StData;
            end
          end
          StData: begin
            if (!tick) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              shift_q <= {rx_s, shift_q[7:1]};
              cnt_q   <= BaudLoad;
              bit_q   <= bit_q + 3'd1;
`ifdef VIP_UART_MON_PARITY_EN
              if (bit_q == 3'd7) state_q <= StParity;
`else
              if (bit_q == 3'd7) state_q <= StStop;
`endif
            end
          end
`ifdef VIP_UART_MON_PARITY_EN
          StParity: begin
            if (!tick) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              cnt_q   <= BaudLoad;
              state_q <= StStop;
            end
          end
`endif
          StStop: begin
            if (!tick) begin
              cnt_q <= cnt_q - 1'b1;
            end else if (rx_s) begin
              state_q <= StIdle;  // leave mid-stop-bit so a back-to-back start is caught
            end else begin
              state_q <= StBreak;
              if (!clear_i) ferr_q <= 1'b1;
            end
          end
          StBreak: begin
            if (rx_s) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end

    assign push[c]      = (state_q == StStop) && tick && rx_s;
    assign push_data[c] = shift_q;

    logic [7:0]      mem_q [FifoDepth];
    logic [PtrW-1:0] wr_q, rd_q;
    logic [15:0]     acc_cnt_q;
    logic            ovf_q, full, push_ok;

    assign full     = (wr_q - rd_q) == PtrW'(FifoDepth);
    assign empty[c] = (wr_q == rd_q);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push_ok  = push[c] && !clear_i && (!full || pop[c]);
    assign head[c]  = mem_q[rd_q[AddrW-1:0]];
    assign pop[c]   = m_valid_o && m_ready_i && (m_ch_o == ChW'(c));

    // FIFO storage
    always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q[AddrW-1:0]] <= push_data[c];
    end

    // FIFO pointers, accepted-byte counter and overflow flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_q      <= '0;
        rd_q      <= '0;
        acc_cnt_q <= '0;
        ovf_q     <= 1'b0;
      end else if (clear_i) begin
        wr_q      <= '0;
        rd_q      <= '0;
        acc_cnt_q <= '0;
        ovf_q     <= 1'b0;
      end else begin
        if (push_ok) begin
          wr_q      <= wr_q + 1'b1;
          acc_cnt_q <= acc_cnt_q + 16'd1;
        end
        if (pop[c]) rd_q <= rd_q + 1'b1;
        if (push[c] && full && !pop[c]) ovf_q <= 1'b1;
      end
    end

    assign frame_err_o[c]         = ferr_q;
    assign overflow_o[c]          = ovf_q;
    assign rx_cnt_o[c*16 +: 16]   = acc_cnt_q;
  end

`ifndef VIP_UART_MON_PARITY_EN
  logic unused_parity_cfg;
  assign unused_parity_cfg = OddParity;
  assign parity_err_o      = '0;
`endif

  logic [ChW-1:0] ptr_q, lock_ch_q, sel, cand;
  logic           lock_q;

  // Round-robin pick; a stalled beat keeps its channel until it is accepted
  always_comb begin
    sel  = ptr_q;
    cand = '0;
    if (lock_q) begin
      sel = lock_ch_q;
    end else begin
      for (int i = int'(NumCh) - 1; i >= 0; i--) begin
        cand = ChW'((int'(ptr_q) + i) % int'(NumCh));
        if (!empty[cand]) sel = cand;
      end
    end
  end

  assign m_valid_o = !empty[sel];
  assign m_data_o  = m_valid_o ? head[sel] : 8'h00;
  assign m_ch_o    = m_valid_o ? sel : '0;

  // Grant pointer and stall lock
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= m_valid_o && !m_ready_i && !clear_i;
      lock_ch_q <= sel;
      if (m_valid_o && m_ready_i) begin
        ptr_q <= (int'(sel) == int'(NumCh) - 1) ? '0 : sel + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vip_uart_mon.sv
// Bench for vip_uart_mon: directed and random frames on two channels, checked against a
// queue-based model of expected beats, counters and sticky flags.
`timescale 1ns/1ps
module tb_vip_uart_mon;
  localparam int unsigned NumCh     = 2;
  localparam int unsigned BaudDiv   = 4;
  localparam int unsigned FifoDepth = 8;
  localparam bit          OddP      = 1'b0;

  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, m_ready = 1'b0;
  logic        rx0 = 1'b1, rx1 = 1'b1;
  logic [1:0]  rx;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ch;
  logic [1:0]  ferr, perr, ovf;
  logic [31:0] cnt;

  assign rx = {rx1, rx0};
  always #5 clk = ~clk;

  vip_uart_mon #(
    .NumCh(NumCh), .BaudDiv(BaudDiv), .FifoDepth(FifoDepth), .OddParity(OddP)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .rx_i(rx),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_ch_o(m_ch),
    .frame_err_o(ferr), .parity_err_o(perr), .overflow_o(ovf), .rx_cnt_o(cnt)
  );

  typedef struct packed {logic ch; logic [7:0] data;} beat_t;

  int          vectors = 0, miscompares = 0;
  beat_t       exp_q[$];
  beat_t       log_q[$];
  logic [15:0] exp_cnt [2];
  logic [1:0]  exp_ferr, exp_perr, exp_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: one entry per byte that should come out, in per-channel order
  function automatic void model_push(input logic ch, input logic [7:0] d);
    int    occ = 0;
    beat_t b;
    foreach (exp_q[i]) if (exp_q[i].ch == ch) occ++;
    if (!m_ready && occ >= int'(FifoDepth)) begin
      exp_ovf[ch] = 1'b1;
    end else begin
      b.ch = ch; b.data = d;
      exp_q.push_back(b);
      exp_cnt[ch] = exp_cnt[ch] + 16'd1;
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    exp_cnt[0] = '0; exp_cnt[1] = '0;
    exp_ferr = '0; exp_perr = '0; exp_ovf = '0;
  endfunction

  // Output monitor: checks every accepted beat and stability under back-pressure
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_ch;
  int         found;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
        chk("hold_ch", 32'(m_ch), 32'(prev_ch));
      end
      if (m_valid && m_ready) begin
        found = -1;
        for (int i = 0; i < exp_q.size(); i++) if (found < 0 && exp_q[i].ch == m_ch) found = i;
        if (found < 0) begin
          chk("unexpected_beat", {23'd0, m_ch, m_data}, 32'hDEAD_BEEF);
        end else begin
          chk($sformatf("beat_ch%0d", m_ch), 32'(m_data), 32'(exp_q[found].data));
          exp_q.delete(found);
        end
        log_q.push_back({m_ch, m_data});
      end
      prev_stall = m_valid && !m_ready && !clear;
      prev_data  = m_data;
      prev_ch    = m_ch;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int ch, input logic v);
    if (ch == 0) rx0 = v; else rx1 = v;
  endtask

  task automatic send_frame(input int ch, input logic [7:0] d, input logic stop,
                            input int low_bits, input logic par_bad);
    set_rx(ch, 1'b0); cyc(BaudDiv);
    for (int i = 0; i < 8; i++) begin set_rx(ch, d[i]); cyc(BaudDiv); end
`ifdef VIP_UART_MON_PARITY_EN
    set_rx(ch, (^d) ^ OddP ^ par_bad); cyc(BaudDiv);
`else
    if (par_bad) $display("note: parity request ignored in 8N1 build");
`endif
    set_rx(ch, stop); cyc(BaudDiv);
    if (!stop) cyc(BaudDiv * low_bits);
    set_rx(ch, 1'b1); cyc(2 * BaudDiv);
  endtask

  task automatic send_pair(input logic [7:0] d0, input logic [7:0] d1);
    model_push(1'b0, d0); model_push(1'b1, d1);
    fork
      send_frame(0, d0, 1'b1, 0, 1'b0);
      send_frame(1, d1, 1'b1, 0, 1'b0);
    join
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("%s_ferr%0d", tag, c), 32'(ferr[c]), 32'(exp_ferr[c]));
      chk($sformatf("%s_perr%0d", tag, c), 32'(perr[c]), 32'(exp_perr[c]));
      chk($sformatf("%s_ovf%0d", tag, c), 32'(ovf[c]), 32'(exp_ovf[c]));
      chk($sformatf("%s_cnt%0d", tag, c), 32'(cnt[c*16 +: 16]), 32'(exp_cnt[c]));
    end
    cyc(1);
  endtask

  task automatic chk_log(input string tag, input int idx, input logic ch, input logic [7:0] d);
    if (log_q.size() > idx) chk(tag, 32'(log_q[idx]), 32'({ch, d}));
    else chk({tag, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 200) begin cyc(1); n++; end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; clear = 1'b0;
    model_clear(); log_q.delete();
    cyc(3);
    rst_n = 1'b1; cyc(2);
  endtask

  logic [7:0] r0, r1;
  int         mode, nlog;

  initial begin
    exp_cnt[0] = '0; exp_cnt[1] = '0;
    exp_ferr = '0; exp_perr = '0; exp_ovf = '0;

    // Reset values
    cyc(2);
    @(negedge clk);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_ch", 32'(m_ch), 32'd0);
    chk("rst_flags", {26'd0, ferr, perr, ovf}, 32'd0);
    chk("rst_cnt", cnt, 32'd0);
    cyc(1);
    do_reset();
    m_ready = 1'b1;

    // Single byte on ch0
    model_push(1'b0, 8'h41);
    send_frame(0, 8'h41, 1'b1, 0, 1'b0);
    check_state("single");
    chk_log("single_beat", 0, 1'b0, 8'h41);
    chk("single_nbeats", 32'(log_q.size()), 32'd1);

    // Simultaneous arrival from reset: ch0 first, then ch1, then ch0 again
    do_reset();
    m_ready = 1'b1;
    send_pair(8'h53, 8'h42);
    chk_log("pair_first", 0, 1'b0, 8'h53);
    chk_log("pair_second", 1, 1'b1, 8'h42);
    model_push(1'b0, 8'h5A);
    send_frame(0, 8'h5A, 1'b1, 0, 1'b0);
    chk_log("next_ch0", 2, 1'b0, 8'h5A);
    // Pointer now at ch1: a simultaneous pair must come out ch1 first
    send_pair(8'h11, 8'h22);
    chk_log("rr_first", 3, 1'b1, 8'h22);
    chk_log("rr_second", 4, 1'b0, 8'h11);
    check_state("pair");

    // Stop bit low, held in break, then a good frame
    log_q.delete();
    exp_ferr[1] = 1'b1;
    send_frame(1, 8'h55, 1'b0, 3, 1'b0);
    model_push(1'b1, 8'h48);
    send_frame(1, 8'h48, 1'b1, 0, 1'b0);
    check_state("break");
    chk("break_nbeats", 32'(log_q.size()), 32'd1);
    chk_log("break_beat", 0, 1'b1, 8'h48);

    // One-cycle glitch: no beat, no flag, decoder still ready afterwards
    log_q.delete();
    rx0 = 1'b0; cyc(1); rx0 = 1'b1; cyc(12);
    chk("glitch_nbeats", 32'(log_q.size()), 32'd0);
    check_state("glitch");
    r0 = 8'($urandom_range(0, 255));
    model_push(1'b0, r0);
    send_frame(0, r0, 1'b1, 0, 1'b0);
    chk_log("post_glitch", 0, 1'b0, r0);

    // Overflow with back-pressure
    clear = 1'b1; cyc(1); clear = 1'b0; model_clear(); log_q.delete();
    m_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      model_push(1'b0, 8'(i));
      send_frame(0, 8'(i), 1'b1, 0, 1'b0);
    end
    check_state("ovf");
    @(negedge clk);
    chk("ovf_cnt_abs", 32'(cnt[15:0]), 32'd8);
    chk("ovf_head", 32'(m_data), 32'h01);
    cyc(1);
    m_ready = 1'b1;
    drain();
    for (int i = 0; i < 8; i++) chk_log($sformatf("ovf_drain%0d", i), i, 1'b0, 8'(i + 1));

    // Random traffic with random back-pressure
    for (int it = 0; it < 8; it++) begin
      m_ready = 1'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 2));
      r0 = 8'($urandom); r1 = 8'($urandom);
      if (mode == 2) begin
        send_pair(r0, r1);
      end else begin
        model_push(1'(mode), r0);
        send_frame(mode, r0, 1'b1, 0, 1'b0);
      end
    end
    m_ready = 1'b1;
    drain();
    check_state("rand");

`ifdef VIP_UART_MON_PARITY_EN
    // Bad parity still delivers the byte
    log_q.delete();
    exp_perr[0] = 1'b1;
    model_push(1'b0, 8'h07);
    send_frame(0, 8'h07, 1'b1, 0, 1'b1);
    check_state("parity");
    chk_log("parity_beat", 0, 1'b0, 8'h07);
`endif

    // Clear with a byte pending
    m_ready = 1'b0;
    model_push(1'b1, 8'hC3);
    send_frame(1, 8'hC3, 1'b1, 0, 1'b0);
    @(negedge clk);
    chk("pre_clear_valid", 32'(m_valid), 32'd1);
    cyc(1);
    clear = 1'b1; cyc(1); clear = 1'b0;
    model_clear();
    @(negedge clk);
    chk("clear_valid", 32'(m_valid), 32'd0);
    cyc(1);
    check_state("clear");
    nlog = log_q.size();
    m_ready = 1'b1; cyc(6);
    chk("clear_no_beats", 32'(log_q.size()), 32'(nlog));
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
